// File: rtl/led_bar_drain.sv
// Drains a loaded left (5) and right (7) LED bar one LED per tick, each side paced by its own counter.
// Define LED_DRAIN_REFILL_EN to reload both bars from their captured patterns once both are dark.
module ledDrainSide #(
  parameter int WIDTH     = 5,
  parameter int THRESH    = 1300,
  parameter int LOW_FIRST = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] fill,
  input  logic             en,
  input  logic             refill,
  output logic [WIDTH-1:0] led,
  output logic             isEmpty,
  output logic             emptyNext,
  output logic             busyNext
);
  typedef enum logic [1:0] {IDLE, LOADED, DRAINING, EMPTY} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] bar, barNext, latch, cleared;
  logic [31:0]      count, countNext;

  // Extinguish exactly one lit LED: lowest index first on the left, highest first on the right.
  function automatic logic [WIDTH-1:0] clearOne(input logic [WIDTH-1:0] v);
    logic done;
    clearOne = v;
    done     = 1'b0;
    if (LOW_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i] && !done) begin
          clearOne[i] = 1'b0;
          done        = 1'b1;
        end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i] && !done) begin
          clearOne[i] = 1'b0;
          done        = 1'b1;
        end
    end
  endfunction

  always_comb begin
    stateNext = state;
    barNext   = bar;
    countNext = count;
    cleared   = clearOne(bar);
    if (load) begin
      barNext   = fill;
      countNext = 32'd0;
      stateNext = (|fill) ? LOADED : EMPTY;
    end else begin
      case (state)
        LOADED: if (en) begin
          stateNext = DRAINING;
          countNext = count + 32'd1;
        end
        DRAINING: if (en) begin
          if (count == 32'(THRESH)) begin
            countNext = 32'd0;
            barNext   = cleared;
            if (cleared == '0) stateNext = EMPTY;
          end else begin
            countNext = count + 32'd1;
          end
        end
        EMPTY: if (refill && |latch) begin
          barNext   = latch;
          countNext = 32'd0;
          stateNext = LOADED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      bar   <= '0;
      latch <= '0;
      count <= 32'd0;
    end else begin
      state <= stateNext;
      bar   <= barNext;
      count <= countNext;
      if (load) latch <= fill;
    end
  end

  assign led       = bar;
  assign isEmpty   = (state == EMPTY);
  assign emptyNext = (stateNext == EMPTY);
  assign busyNext  = (stateNext == LOADED) || (stateNext == DRAINING);
endmodule

module led_bar_drain #(
  parameter int THRESH_L = 1300,
  parameter int THRESH_R = 2600
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic [4:0] fill_l,
  input  logic [6:0] fill_r,
  input  logic       en_l,
  input  logic       en_r,
  output logic [4:0] ledL,
  output logic [6:0] ledR,
  output logic       busy,
  output logic       drained
);
`ifdef LED_DRAIN_REFILL_EN
  localparam logic REFILL_ON = 1'b1;
`else
  localparam logic REFILL_ON = 1'b0;
`endif

  logic emptyL, emptyR, emptyNextL, emptyNextR, busyNextL, busyNextR, refill;

  // Refill fires only from the cycle where both sides already sit in EMPTY.
  assign refill = REFILL_ON && emptyL && emptyR;

  ledDrainSide #(.WIDTH(5), .THRESH(THRESH_L), .LOW_FIRST(1)) leftSide (
    .clock(clock), .resetn(resetn), .load(load), .fill(fill_l), .en(en_l),
    .refill(refill), .led(ledL), .isEmpty(emptyL), .emptyNext(emptyNextL),
    .busyNext(busyNextL)
  );

  ledDrainSide #(.WIDTH(7), .THRESH(THRESH_R), .LOW_FIRST(0)) rightSide (
    .clock(clock), .resetn(resetn), .load(load), .fill(fill_r), .en(en_r),
    .refill(refill), .led(ledR), .isEmpty(emptyR), .emptyNext(emptyNextR),
    .busyNext(busyNextR)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy    <= 1'b0;
      drained <= 1'b0;
    end else begin
      busy    <= busyNextL | busyNextR;
      drained <= emptyNextL & emptyNextR;
    end
  end
endmodule

// File: tb/tb_led_bar_drain.sv
// Randomised bench for led_bar_drain against a bar/phase reference model (small thresholds).
module tb_led_bar_drain;
  localparam int TL = 3;
  localparam int TR = 5;

  logic       clock = 1'b0;
  logic       resetn, load, en_l, en_r;
  logic [4:0] fill_l;
  logic [6:0] fill_r;
  logic [4:0] ledL;
  logic [6:0] ledR;
  logic       busy, drained;

  int total = 0;
  int bad   = 0;

  // Model: lit bars, captured patterns, enabled edges since the last clear, and "has been loaded".
  logic [6:0] mBar[2];
  logic [6:0] mLatch[2];
  int         mPhase[2];
  bit         mEver[2];

  always #5 clock = ~clock;

  led_bar_drain #(.THRESH_L(TL), .THRESH_R(TR)) dut (
    .clock(clock), .resetn(resetn), .load(load), .fill_l(fill_l), .fill_r(fill_r),
    .en_l(en_l), .en_r(en_r), .ledL(ledL), .ledR(ledR), .busy(busy), .drained(drained)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelEdge(input logic r, input logic ld, input logic [4:0] fl,
                           input logic [6:0] fr, input logic el, input logic er);
    bit   bothDark;
    bit   en[2];
    int   th[2];
    logic done;
    en[0] = el; en[1] = er;
    th[0] = TL; th[1] = TR;
    if (!r) begin
      for (int s = 0; s < 2; s++) begin
        mBar[s] = '0; mLatch[s] = '0; mPhase[s] = 0; mEver[s] = 1'b0;
      end
    end else if (ld) begin
      mBar[0] = {2'b00, fl};
      mBar[1] = fr;
      for (int s = 0; s < 2; s++) begin
        mLatch[s] = mBar[s]; mPhase[s] = 0; mEver[s] = 1'b1;
      end
    end else begin
      bothDark = mEver[0] && mEver[1] && mBar[0] == 0 && mBar[1] == 0;
`ifdef LED_DRAIN_REFILL_EN
      if (bothDark) begin
        for (int s = 0; s < 2; s++)
          if (mLatch[s] != 0) begin
            mBar[s] = mLatch[s]; mPhase[s] = 0;
          end
      end else
`endif
      for (int s = 0; s < 2; s++) begin
        if (mBar[s] != 0 && en[s]) begin
          mPhase[s]++;
          if (mPhase[s] == th[s] + 1) begin
            mPhase[s] = 0;
            done = 1'b0;
            if (s == 0) begin
              for (int i = 0; i < 5; i++)
                if (mBar[0][i] && !done) begin mBar[0][i] = 1'b0; done = 1'b1; end
            end else begin
              for (int i = 6; i >= 0; i--)
                if (mBar[1][i] && !done) begin mBar[1][i] = 1'b0; done = 1'b1; end
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic ld, input logic [4:0] fl,
                      input logic [6:0] fr, input logic el, input logic er);
    @(negedge clock);
    resetn = r; load = ld; fill_l = fl; fill_r = fr; en_l = el; en_r = er;
    @(posedge clock);
    modelEdge(r, ld, fl, fr, el, er);
    #1;
    checkVal("ledL", 32'(ledL), 32'(mBar[0]));
    checkVal("ledR", 32'(ledR), 32'(mBar[1]));
    checkVal("busy", 32'(busy), 32'(mBar[0] != 0 || mBar[1] != 0));
    checkVal("drained", 32'(drained),
             32'(mEver[0] && mEver[1] && mBar[0] == 0 && mBar[1] == 0));
  endtask

  initial begin
    logic [4:0] fl;
    logic [6:0] fr;
    int         pick;
    resetn = 1'b0; load = 1'b0; fill_l = '0; fill_r = '0; en_l = 1'b0; en_r = 1'b0;

    // Reset with load asserted must leave everything dark.
    tick(1'b0, 1'b1, 5'h1F, 7'h7F, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 5'h1F, 7'h7F, 1'b1, 1'b1);
    checkVal("rst_ledL", 32'(ledL), 32'h0);
    checkVal("rst_ledR", 32'(ledR), 32'h0);
    checkVal("rst_busy", 32'(busy), 32'h0);
    checkVal("rst_drained", 32'(drained), 32'h0);

    // Full drain timing.
    tick(1'b1, 1'b1, 5'h1F, 7'h7F, 1'b0, 1'b0);
    checkVal("full_busy0", 32'(busy), 32'h1);
    for (int e = 1; e <= 42; e++) begin
      tick(1'b1, 1'b0, 5'h00, 7'h00, 1'b1, 1'b1);
      if (e == 4)  checkVal("full_ledL_e4", 32'(ledL), 32'h1E);
      if (e == 6)  checkVal("full_ledR_e6", 32'(ledR), 32'h3F);
      if (e == 20) checkVal("full_ledL_e20", 32'(ledL), 32'h00);
      if (e == 41) checkVal("full_drained_e41", 32'(drained), 32'h0);
      if (e == 42) begin
        checkVal("full_ledR_e42", 32'(ledR), 32'h00);
        checkVal("full_drained_e42", 32'(drained), 32'h1);
        checkVal("full_busy_e42", 32'(busy), 32'h0);
      end
    end

    // Sparse left, empty right.
    tick(1'b1, 1'b1, 5'h12, 7'h00, 1'b0, 1'b0);
    checkVal("sparse_drained0", 32'(drained), 32'h0);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1, 1'b0, 5'h00, 7'h00, 1'b1, 1'b1);
      if (e == 4) checkVal("sparse_ledL_e4", 32'(ledL), 32'h10);
      if (e == 8) begin
        checkVal("sparse_ledL_e8", 32'(ledL), 32'h00);
        checkVal("sparse_drained_e8", 32'(drained), 32'h1);
      end
    end

    // Load during a drain restarts the counter.
    tick(1'b1, 1'b1, 5'h1F, 7'h7F, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) tick(1'b1, 1'b0, 5'h00, 7'h00, 1'b1, 1'b1);
    checkVal("mid_ledL_pre", 32'(ledL), 32'h1C);
    tick(1'b1, 1'b1, 5'h05, 7'h7F, 1'b1, 1'b1);
    checkVal("mid_ledL_load", 32'(ledL), 32'h05);
    for (int e = 1; e <= 4; e++) tick(1'b1, 1'b0, 5'h00, 7'h00, 1'b1, 1'b1);
    checkVal("mid_ledL_e4", 32'(ledL), 32'h04);

    // Randomised run against the model.
    for (int c = 0; c < 3000; c++) begin
      pick = int'($urandom_range(0, 99));
      fl = 5'($urandom);
      fr = 7'($urandom);
      case ($urandom_range(0, 3))
        0: begin fl = 5'h00; fr = 7'h00; end
        1: begin fl = 5'h1F; fr = 7'h7F; end
        default: ;
      endcase
      tick(pick >= 2, pick >= 2 && pick < 6, fl, fr,
           $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
